// File: rtl/part_74s163_pkg.sv
// rtl/part_74s163_pkg.sv - shared constants and next-state helper for the 74S163 model
package part_74s163_pkg;

  localparam int REG_DELAY_DEFAULT = 0;
  localparam int REG_DELAY_ALT     = 4;
  localparam int COUNT_W           = 4;

  // Ternaries rather than if/else so an X control merges into an X result
  function automatic logic stage_next(
    input logic clr_n,
    input logic load_n,
    input logic tgl,
    input logic d,
    input logic q
  );
    return clr_n ? (load_n ? (tgl ? ~q : q) : d) : 1'b0;
  endfunction

  function automatic bit reg_delay_ok(input int dly);
    return (dly == REG_DELAY_DEFAULT) || (dly == REG_DELAY_ALT);
  endfunction

endpackage

// File: rtl/part_74s163_stage.sv
// rtl/part_74s163_stage.sv - one bit-slice of the counter: clear > load > toggle > hold
module part_74s163_stage
  import part_74s163_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic load_n,
  input  logic tgl,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    q <= stage_next(clr_n, load_n, tgl, d, q);
  end

endmodule

// File: rtl/part_74s163.sv
// rtl/part_74s163.sv - 74S163 synchronous 4-bit binary counter, sync clear and load, RCO
module part_74s163
  import part_74s163_pkg::*;
#(
  parameter int REG_DELAY = REG_DELAY_DEFAULT
) (
  input  logic clk,
  input  logic clr_n,
  input  logic load_n,
  input  logic enp,
  input  logic ent,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  output logic qa,
  output logic qb,
  output logic qc,
  output logic qd,
  output logic rco
);

  generate
    if (!reg_delay_ok(REG_DELAY)) begin : g_bad_delay
      $error("part_74s163: REG_DELAY must be 0 or 4");
    end
  endgenerate

  logic [COUNT_W-1:0] q;
  logic [COUNT_W-1:0] d;
  logic [COUNT_W-1:0] tgl;

  assign d = {i3, i2, i1, i0};

  // A bit toggles when both enables are high and every lower bit is 1
  assign tgl[0] = enp & ent;
  assign tgl[1] = tgl[0] & q[0];
  assign tgl[2] = tgl[1] & q[1];
  assign tgl[3] = tgl[2] & q[2];

  genvar g;
  generate
    for (g = 0; g < COUNT_W; g++) begin : g_stage
      part_74s163_stage u_stage (
        .clk    (clk),
        .clr_n  (clr_n),
        .load_n (load_n),
        .tgl    (tgl[g]),
        .d      (d[g]),
        .q      (q[g])
      );
    end
  endgenerate

  assign qa  = q[0];
  assign qb  = q[1];
  assign qc  = q[2];
  assign qd  = q[3];
  assign rco = ent & (&q);

endmodule
